// File: rtl/rv_pkg.sv
// Control encodings and stage bookkeeping types shared by the hazard sequencer
// and the other consumers of control-unit outputs.
package rv_pkg;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_EXMEM   = 2'b01;
  localparam logic [1:0] FWD_MEMWB   = 2'b10;

  typedef enum logic {
    RUN         = 1'b0,
    FETCH_FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       write_reg;
    logic       read_mem;
    logic       branch;
    logic       u_branch;
  } stage_info_t;

endpackage

// File: rtl/fwd_select.sv
// Operand source selection for one ID source register: the youngest in-flight
// producer of that register wins, and x0 is never forwarded.
module fwd_select
  import rv_pkg::*;
(
  input  logic [4:0] src,
  input  logic       ex_valid,
  input  logic [4:0] ex_rd,
  input  logic       ex_write_reg,
  input  logic       mem_valid,
  input  logic [4:0] mem_rd,
  input  logic       mem_write_reg,
  output logic [1:0] sel
);

  logic ex_hit_s;
  logic mem_hit_s;

  assign ex_hit_s  = ex_valid  & ex_write_reg  & (ex_rd  != 5'd0) & (src == ex_rd);
  assign mem_hit_s = mem_valid & mem_write_reg & (mem_rd != 5'd0) & (src == mem_rd);

  always_comb begin
    sel = FWD_REGFILE;
    if (ex_hit_s) begin
      sel = FWD_EXMEM;
    end else if (mem_hit_s) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_REGFILE;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding sequencer for the 5-stage core. Tracks EX and MEM
// destination state itself so it only needs the decode-stage control bits.
module pipeline_hazard_ctrl
  import rv_pkg::*;
#(
  parameter int FETCH_LAT = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_write_reg,
  input  logic             id_read_mem,
  input  logic             id_branch,
  input  logic             id_u_branch,
  input  logic             ex_taken,
  input  logic             mem_wait,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pc_redirect,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FLUSH_INIT = 2'(FETCH_LAT);

  stage_info_t      ex_q, ex_d;
  logic             mem_valid_q, mem_valid_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_write_reg_q, mem_write_reg_d;
  hz_state_t        state_q, state_d;
  logic [1:0]       ff_cnt_q, ff_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic             redirect_s;
  logic             hazard_s;
  logic [1:0]       fwd_a_raw_s;
  logic [1:0]       fwd_b_raw_s;

  fwd_select u_fwd_a (
    .src(id_rs1), .ex_valid(ex_q.valid), .ex_rd(ex_q.rd), .ex_write_reg(ex_q.write_reg),
    .mem_valid(mem_valid_q), .mem_rd(mem_rd_q), .mem_write_reg(mem_write_reg_q), .sel(fwd_a_raw_s)
  );

  fwd_select u_fwd_b (
    .src(id_rs2), .ex_valid(ex_q.valid), .ex_rd(ex_q.rd), .ex_write_reg(ex_q.write_reg),
    .mem_valid(mem_valid_q), .mem_rd(mem_rd_q), .mem_write_reg(mem_write_reg_q), .sel(fwd_b_raw_s)
  );

  assign redirect_s = ex_q.valid & (ex_q.u_branch | (ex_q.branch & ex_taken));
  assign hazard_s   = id_valid & ex_q.valid & ex_q.read_mem & (ex_q.rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_q.rd)) | (id_use_rs2 & (id_rs2 == ex_q.rd)));

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  // Priority: memory freeze, then redirect, then wrong-path flush, then load-use.
  always_comb begin
    pc_stall        = 1'b0;
    if_id_stall     = 1'b0;
    if_id_flush     = 1'b0;
    id_ex_bubble    = 1'b0;
    pc_redirect     = 1'b0;
    fwd_a_sel       = FWD_REGFILE;
    fwd_b_sel       = FWD_REGFILE;
    state_d         = state_q;
    ff_cnt_d        = ff_cnt_q;
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    ex_d            = ex_q;
    mem_valid_d     = mem_valid_q;
    mem_rd_d        = mem_rd_q;
    mem_write_reg_d = mem_write_reg_q;

    if (mem_wait) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else begin
      fwd_a_sel = fwd_a_raw_s;
      fwd_b_sel = fwd_b_raw_s;
      if (redirect_s) begin
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        flush_cnt_d  = flush_cnt_q + CNT_W'(2);
        state_d      = FETCH_FLUSH;
        ff_cnt_d     = FLUSH_INIT;
      end else if (state_q == FETCH_FLUSH) begin
        // ID only carries wrong-path bubbles here, so load-use is not evaluated.
        if_id_flush = 1'b1;
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
        if (ff_cnt_q == 2'd1) begin
          state_d  = RUN;
          ff_cnt_d = 2'd0;
        end else begin
          ff_cnt_d = ff_cnt_q - 2'd1;
        end
      end else if (hazard_s) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_bubble = 1'b1;
        stall_cnt_d  = stall_cnt_q + CNT_W'(1);
      end else begin
        state_d = RUN;
      end

      ex_d.valid      = id_valid & ~id_ex_bubble;
      ex_d.rd         = id_rd;
      ex_d.write_reg  = id_write_reg;
      ex_d.read_mem   = id_read_mem;
      ex_d.branch     = id_branch;
      ex_d.u_branch   = id_u_branch;
      mem_valid_d     = ex_q.valid;
      mem_rd_d        = ex_q.rd;
      mem_write_reg_d = ex_q.write_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q            <= '0;
      mem_valid_q     <= 1'b0;
      mem_rd_q        <= 5'd0;
      mem_write_reg_q <= 1'b0;
      state_q         <= RUN;
      ff_cnt_q        <= 2'd0;
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
    end else begin
      ex_q            <= ex_d;
      mem_valid_q     <= mem_valid_d;
      mem_rd_q        <= mem_rd_d;
      mem_write_reg_q <= mem_write_reg_d;
      state_q         <= state_d;
      ff_cnt_q        <= ff_cnt_d;
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scenarios plus randomized traffic compared against an instruction-level
// reference model of the hazard rules. Narrow counters exercise wrap-around.
module tb_pipeline_hazard_ctrl;

  localparam int FL = 3;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic [4:0] id_rs1 = 5'd0, id_rs2 = 5'd0, id_rd = 5'd0;
  logic id_write_reg = 1'b0, id_read_mem = 1'b0, id_branch = 1'b0, id_u_branch = 1'b0;
  logic ex_taken = 1'b0, mem_wait = 1'b0;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [8:0] got;

  assign got = {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect, fwd_a_sel, fwd_b_sel};

  pipeline_hazard_ctrl #(.FETCH_LAT(FL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
    .id_write_reg(id_write_reg), .id_read_mem(id_read_mem), .id_branch(id_branch),
    .id_u_branch(id_u_branch), .ex_taken(ex_taken), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pc_redirect(pc_redirect), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the instruction in EX, the one in MEM, wrong-path fetches left to discard.
  logic mx_v = 1'b0, mx_wr = 1'b0, mx_rm = 1'b0, mx_br = 1'b0, mx_ub = 1'b0;
  logic [4:0] mx_rd = 5'd0;
  logic mm_v = 1'b0, mm_wr = 1'b0;
  logic [4:0] mm_rd = 5'd0;
  int m_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  function automatic logic [1:0] m_src(input logic [4:0] r);
    if (r != 5'd0 && mx_v && mx_wr && r == mx_rd) return 2'b01;
    if (r != 5'd0 && mm_v && mm_wr && r == mm_rd) return 2'b10;
    return 2'b00;
  endfunction

  // Expected {pc_stall, if_id_stall, if_id_flush, id_ex_bubble, pc_redirect, fwd_a, fwd_b}.
  function automatic logic [8:0] m_expect();
    logic redir, haz;
    logic [4:0] ctl;
    if (mem_wait) return 9'b110000000;
    redir = mx_v && (mx_ub || (mx_br && ex_taken));
    haz = (m_left == 0) && id_valid && mx_v && mx_rm && (mx_rd != 5'd0) &&
          ((id_use_rs1 && id_rs1 == mx_rd) || (id_use_rs2 && id_rs2 == mx_rd));
    if (redir) ctl = 5'b00111;
    else if (m_left > 0) ctl = 5'b00100;
    else if (haz) ctl = 5'b11010;
    else ctl = 5'b00000;
    return {ctl, m_src(id_rs1), m_src(id_rs2)};
  endfunction

  task automatic m_tick();
    logic [8:0] e;
    e = m_expect();
    if (rst) begin
      mx_v = 1'b0; mx_wr = 1'b0; mx_rm = 1'b0; mx_br = 1'b0; mx_ub = 1'b0; mx_rd = 5'd0;
      mm_v = 1'b0; mm_wr = 1'b0; mm_rd = 5'd0;
      m_left = 0; m_stall = 0; m_flush = 0;
    end else if (!mem_wait) begin
      if (e[4]) begin
        m_flush += 2;
        m_left = FL;
      end else if (m_left > 0) begin
        m_flush += 1;
        m_left -= 1;
      end else if (e[5]) begin
        m_stall += 1;
      end
      mm_v = mx_v; mm_rd = mx_rd; mm_wr = mx_wr;
      mx_v = id_valid && !e[5];
      mx_rd = id_rd; mx_wr = id_write_reg; mx_rm = id_read_mem;
      mx_br = id_branch; mx_ub = id_u_branch;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_tick();
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                        input logic u2, input logic [4:0] rd, input logic wr, input logic rm,
                        input logic br, input logic ub);
    id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
    id_rd = rd; id_write_reg = wr; id_read_mem = rm; id_branch = br; id_u_branch = ub;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_wait = 1'b0; ex_taken = 1'b0;
    nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_id(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    nop();
    @(negedge clk);
    checks++; if (got !== 9'd0) begin errors++; $display("FAIL reset_outs got %b exp %b", got, 9'd0); end
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL reset_flush_cnt got %0d exp 0", flush_cnt); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);  // LW x5,0(x1)
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);  // ADD x6,x5,x2
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b11010) begin errors++; $display("FAIL lu_stall got %b exp 11010", got[8:4]); end
    tick();
    @(negedge clk);
    checks++; if (got !== 9'b000001000) begin errors++; $display("FAIL lu_after got %b exp 000001000", got); end
    checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);  // ADDI x3,x0,7
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);  // SUB x4,x3,x3
    @(negedge clk);
    checks++; if (got !== 9'b000000101) begin errors++; $display("FAIL fwd_exmem got %b exp 000000101", got); end
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (got !== 9'b000001010) begin errors++; $display("FAIL fwd_memwb got %b exp 000001010", got); end
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);  // dest x0
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (got !== 9'd0) begin errors++; $display("FAIL fwd_x0 got %b exp 000000000", got); end
    do_reset();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (got !== 9'b000000101) begin errors++; $display("FAIL fwd_newest got %b exp 000000101", got); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);  // BEQ x1,x2
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_taken = 1'b1;
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00111) begin errors++; $display("FAIL br_redirect got %b exp 00111", got[8:4]); end
    tick();
    ex_taken = 1'b0;
    nop();
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      checks++; if (got[8:4] !== 5'b00100) begin errors++; $display("FAIL br_fetch_flush %0d got %b exp 00100", k, got[8:4]); end
      tick();
    end
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00000) begin errors++; $display("FAIL br_back_to_run got %b exp 00000", got[8:4]); end
    checks++; if (flush_cnt !== 4'(2 + FL)) begin errors++; $display("FAIL br_flush_cnt got %0d exp %0d", flush_cnt, 2 + FL); end
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd7, 1'b1, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00000) begin errors++; $display("FAIL br_not_taken got %b exp 00000", got[8:4]); end
    tick();
    @(negedge clk);
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL br_nt_flush_cnt got %0d exp 0", flush_cnt); end
    tick();
  endtask

  task automatic test_mem_wait_jal();
    do_reset();
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);  // JAL x1
    tick();
    set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0);  // would forward x1
    mem_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (got !== 9'b110000000) begin errors++; $display("FAIL mw_freeze %0d got %b exp 110000000", k, got); end
      tick();
    end
    mem_wait = 1'b0;
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00111) begin errors++; $display("FAIL mw_redirect got %b exp 00111", got[8:4]); end
    checks++; if (flush_cnt !== 4'd0) begin errors++; $display("FAIL mw_flush_cnt_pre got %0d exp 0", flush_cnt); end
    tick();
    nop();
    @(negedge clk);
    checks++; if (flush_cnt !== 4'd2) begin errors++; $display("FAIL mw_flush_cnt got %0d exp 2", flush_cnt); end
    tick();
  endtask

  task automatic test_redirect_vs_hazard();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0);  // EX looks like a load and a branch
    tick();
    set_id(1'b1, 5'd5, 1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_taken = 1'b1;
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00111) begin errors++; $display("FAIL rh_redirect got %b exp 00111", got[8:4]); end
    tick();
    ex_taken = 1'b0;
    nop();
    @(negedge clk);
    checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL rh_stall_cnt got %0d exp 0", stall_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    nop();
    ex_taken = 1'b1;
    tick();
    ex_taken = 1'b0;
    @(negedge clk);
    checks++; if (got[8:4] !== 5'b00100) begin errors++; $display("FAIL rmf_in_flush got %b exp 00100", got[8:4]); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (got !== 9'd0) begin errors++; $display("FAIL rmf_outs %0d got %b exp 000000000", k, got); end
      checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
        errors++; $display("FAIL rmf_cnts %0d got %0d/%0d exp 0/0", k, stall_cnt, flush_cnt);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [8:0] e, msk;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 199) == 0);
      mem_wait     = ($urandom_range(0, 6) == 0);
      ex_taken     = ($urandom_range(0, 1) == 1);
      id_valid     = ($urandom_range(0, 9) != 0);
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      id_rd        = 5'($urandom_range(0, 3));
      id_use_rs1   = ($urandom_range(0, 3) != 0);
      id_use_rs2   = ($urandom_range(0, 1) == 1);
      id_write_reg = ($urandom_range(0, 3) != 0);
      id_read_mem  = ($urandom_range(0, 2) == 0);
      id_branch    = ($urandom_range(0, 9) == 0);
      id_u_branch  = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      if (!rst) begin
        e = m_expect();
        msk = e[5] ? 9'h1F0 : 9'h1FF;
        checks++; if ((got & msk) !== (e & msk)) begin errors++; $display("FAIL rand_outs cyc %0d got %b exp %b", i, got, e); end
        checks++; if (stall_cnt !== CW'(m_stall)) begin errors++; $display("FAIL rand_stall_cnt cyc %0d got %0d exp %0d", i, stall_cnt, CW'(m_stall)); end
        checks++; if (flush_cnt !== CW'(m_flush)) begin errors++; $display("FAIL rand_flush_cnt cyc %0d got %0d exp %0d", i, flush_cnt, CW'(m_flush)); end
      end
      tick();
    end
    rst = 1'b0;
    mem_wait = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_forward();
    test_branch();
    test_mem_wait_jal();
    test_redirect_vs_hazard();
    test_reset_mid_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
